// File: rtl/piso_shift_tx_pkg.sv
// Shared definitions for the serial word transmitter and any matching receiver:
// FSM state encodings and counter-width helpers.
package piso_shift_tx_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2_f(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width_f(input int value);
    int w;
    w = clog2_f(value);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/bit_rate_div.sv
// DIV-cycle enable generator: counts 0..DIV-1 while not cleared and flags the last count.
module bit_rate_div
  import piso_shift_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width_f(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'sd1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wrapping at DIV-1 and held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out word transmitter: loads DIN on START and shifts it out on Q,
// holding each bit for DIV clocks, with BUSY over the frame and a one-cycle DONE after it.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIN,
  output logic             Q,
  output logic             Qn,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = clog2_f(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 32'sd1);

  logic [0:0]       state_r;
  logic [WIDTH-1:0] shift_r;
  logic [BW-1:0]    bit_cnt_r;
  logic             q_r;
  logic             busy_r;
  logic             done_r;

  logic             tick_s;
  logic             div_clear_s;
  logic [WIDTH-1:0] shift_next_s;
  logic             next_bit_s;
  logic             load_bit_s;

  // Divider only runs while shifting, so every frame starts with a fresh bit period.
  always_comb begin
    div_clear_s = (state_r != ST_SHIFT);
  end

  bit_rate_div #(
    .DIV (DIV)
  ) u_bit_rate_div (
    .clk   (CLK),
    .rst   (RST),
    .clear (div_clear_s),
    .tick  (tick_s)
  );

  // Shift direction and the bit that lands on Q after a load or a shift.
  always_comb begin
    shift_next_s = '0;
    next_bit_s   = 1'b0;
    load_bit_s   = 1'b0;
    if (MSB_FIRST) begin
      shift_next_s = {shift_r[WIDTH-2:0], 1'b0};
      next_bit_s   = shift_r[WIDTH-2];
      load_bit_s   = DIN[WIDTH-1];
    end else begin
      shift_next_s = {1'b0, shift_r[WIDTH-1:1]};
      next_bit_s   = shift_r[1];
      load_bit_s   = DIN[0];
    end
  end

  // Frame FSM: load in IDLE, shift on each divider tick, finish after the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      q_r       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (START) begin
            state_r   <= ST_SHIFT;
            shift_r   <= DIN;
            bit_cnt_r <= '0;
            q_r       <= load_bit_s;
            busy_r    <= 1'b1;
          end else begin
            q_r    <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          done_r <= 1'b0;
          if (tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              state_r   <= ST_IDLE;
              shift_r   <= '0;
              bit_cnt_r <= '0;
              q_r       <= 1'b0;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 1'b1;
              q_r       <= next_bit_s;
            end
          end else begin
            q_r <= q_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          shift_r   <= '0;
          bit_cnt_r <= '0;
          q_r       <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_r;
  assign Qn   = ~q_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: four instances cover MSB/LSB order and DIV of 1, 2 and 4.
module tb_piso_shift_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       start_v [4];
  logic       q_v     [4];
  logic       qn_v    [4];
  logic       busy_v  [4];
  logic       done_v  [4];

  int n_checks;
  int n_errors;

  piso_shift_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_a (
    .CLK(clk), .RST(rst), .START(start_v[0]), .DIN(din),
    .Q(q_v[0]), .Qn(qn_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]));

  piso_shift_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_b (
    .CLK(clk), .RST(rst), .START(start_v[1]), .DIN(din),
    .Q(q_v[1]), .Qn(qn_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]));

  piso_shift_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_c (
    .CLK(clk), .RST(rst), .START(start_v[2]), .DIN(din),
    .Q(q_v[2]), .Qn(qn_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]));

  piso_shift_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) u_d (
    .CLK(clk), .RST(rst), .START(start_v[3]), .DIN(din),
    .Q(q_v[3]), .Qn(qn_v[3]), .BUSY(busy_v[3]), .DONE(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int idx, input logic [7:0] word);
    start_v[idx] = 1'b1;
    din = word;
    tick();
    start_v[idx] = 1'b0;
  endtask

  // seq lists the transmitted bits left to right; poke_cycle >= 0 fires a stray START with DIN=FF.
  task automatic shift_frame(input int idx, input string tag, input logic [7:0] seq, input int div,
                             input int poke_cycle, input logic chain, input logic [7:0] chain_word);
    int k;
    logic eb;
    logic nb;
    k = 0;
    for (int b = 0; b < 8; b++) begin
      for (int d = 0; d < div; d++) begin
        eb = seq[7-b];
        nb = ~eb;
        check_eq({tag, "_q"}, q_v[idx], eb);
        check_eq({tag, "_qn"}, qn_v[idx], nb);
        check_eq({tag, "_busy"}, busy_v[idx], 1'b1);
        check_eq({tag, "_done_early"}, done_v[idx], 1'b0);
        if (k == poke_cycle) begin
          start_v[idx] = 1'b1;
          din = 8'hFF;
        end
        tick();
        start_v[idx] = 1'b0;
        k++;
      end
    end
    check_eq({tag, "_busy_end"}, busy_v[idx], 1'b0);
    check_eq({tag, "_done"}, done_v[idx], 1'b1);
    check_eq({tag, "_q_end"}, q_v[idx], 1'b0);
    check_eq({tag, "_qn_end"}, qn_v[idx], 1'b1);
    if (chain) begin
      start_v[idx] = 1'b1;
      din = chain_word;
      tick();
      start_v[idx] = 1'b0;
      check_eq({tag, "_chain_busy"}, busy_v[idx], 1'b1);
      check_eq({tag, "_chain_done"}, done_v[idx], 1'b0);
    end else begin
      tick();
      check_eq({tag, "_done_clr"}, done_v[idx], 1'b0);
      check_eq({tag, "_idle_busy"}, busy_v[idx], 1'b0);
    end
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    din = 8'h00;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_q", q_v[i], 1'b0);
      check_eq("rst_qn", qn_v[i], 1'b1);
      check_eq("rst_busy", busy_v[i], 1'b0);
      check_eq("rst_done", done_v[i], 1'b0);
    end
    rst = 1'b0;
    tick();

    launch(0, 8'h96);
    shift_frame(0, "msb96", 8'h96, 1, -1, 1'b0, 8'h00);

    launch(1, 8'h96);
    shift_frame(1, "lsb96", 8'h69, 1, -1, 1'b0, 8'h00);

    launch(2, 8'hA5);
    shift_frame(2, "div4", 8'hA5, 4, 10, 1'b0, 8'h00);

    launch(0, 8'h3C);
    shift_frame(0, "busy_ign", 8'h3C, 1, 3, 1'b1, 8'h0F);
    shift_frame(0, "b2b", 8'h0F, 1, -1, 1'b0, 8'h00);

    // Reset in the middle of a DIV=2 frame.
    launch(3, 8'hFF);
    repeat (4) tick();
    check_eq("pre_rst_q", q_v[3], 1'b1);
    check_eq("pre_rst_busy", busy_v[3], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_q", q_v[3], 1'b0);
    check_eq("mid_rst_qn", qn_v[3], 1'b1);
    check_eq("mid_rst_busy", busy_v[3], 1'b0);
    check_eq("mid_rst_done", done_v[3], 1'b0);
    for (int i = 0; i < 20; i++) begin
      check_eq("post_rst_done", done_v[3], 1'b0);
      check_eq("post_rst_busy", busy_v[3], 1'b0);
      tick();
    end
    launch(3, 8'hA5);
    shift_frame(3, "after_rst", 8'hA5, 2, -1, 1'b0, 8'h00);

    // START held high: 8 busy, 1 gap, three times.
    din = 8'h5A;
    start_v[0] = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 27; cyc++) begin
      tick();
      check_eq("held_busy", busy_v[0], (cyc % 9) != 8);
      check_eq("held_done", done_v[0], (cyc % 9) == 8);
      if (done_v[0] === 1'b1) done_cnt++;
    end
    start_v[0] = 1'b0;
    tick();
    check_eq("held_end_busy", busy_v[0], 1'b0);
    check_eq("held_end_done", done_v[0], 1'b0);
    check_eq("held_done_count", done_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
